// File: rtl/multibit_stream_fifo.sv
// Single-clock first-word-fall-through stream FIFO with occupancy flags and an optional overwrite-oldest mode.
// A push shows up on bdata one cycle later; blocking mode drops aready when full, overwrite mode never stalls the producer.
module multibit_stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int OVERWRITE  = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     avalid,
  input  logic [DATA_WIDTH-1:0]    adata,
  output logic                     aready,
  output logic                     bvalid,
  output logic [DATA_WIDTH-1:0]    bdata,
  input  logic                     bready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [CNT_WIDTH-1:0]     drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);
  localparam logic OVW = (OVERWRITE != 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  drop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

  // aready deliberately ignores bready: no same-cycle pass-through when full
  assign aready = ~flush & (~full | OVW);
  assign bvalid = ~empty & ~flush;
  assign bdata  = mem[rptr[AW-1:0]];

  assign push = avalid & aready;
  assign pop  = bvalid & bready;
  assign drop = push & full & ~pop;

  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= adata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      level      <= '0;
      drop_count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PW'(1);
      end
      // an overwrite lands on the oldest slot, so the read side skips past it
      if (pop || drop) begin
        rptr <= rptr + PW'(1);
      end
      if (push && !pop && !full) begin
        level <= level + PW'(1);
      end else if (pop && !push) begin
        level <= level - PW'(1);
      end
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: doc/multibit_stream_fifo.md
Name: multibit_stream_fifo

Overview:
Parametrised single-clock stream FIFO; successor to the 1-deep/2-register FIFO used on the audio input path. It buffers DEPTH words between a valid/ready producer (A side) and a valid/ready consumer (B side), with first-word fall-through. It adds occupancy reporting, almost-full/almost-empty flags, synchronous flush, and an optional overwrite-oldest mode for real-time audio, where stalling the source is not allowed.

Parameters:
DATA_WIDTH, 32, width of adata/bdata
DEPTH, 4, number of storage words; power of 2, >= 2
AF_LEVEL, DEPTH-1, almost_full asserts when level >= AF_LEVEL
AE_LEVEL, 1, almost_empty asserts when level <= AE_LEVEL
OVERWRITE, 0, 0 = blocking (back-pressure on full); 1 = overwrite oldest word on full
CNT_WIDTH, 16, width of saturating drop_count

Ports:
clk  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous clear of contents; does not clear drop_count
avalid  input  1  producer word valid
adata  input  DATA_WIDTH  producer word
aready  output  1  FIFO can accept adata this cycle
bvalid  output  1  bdata holds the oldest stored word
bdata  output  DATA_WIDTH  oldest stored word (FWFT)
bready  input  1  consumer takes bdata this cycle
level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
almost_full  output  1  level >= AF_LEVEL
almost_empty  output  1  level <= AE_LEVEL
drop_count  output  CNT_WIDTH  words discarded by overwrite; saturates at all-ones

Behaviour:
- Reset (clk edge with reset=1): wptr=0, rptr=0, level=0, drop_count=0. Outputs after reset: bvalid=0, aready=1, almost_empty=1, almost_full=0 (for AF_LEVEL>0). Storage contents are not reset; bdata is don't-care while bvalid=0.
- Pointers are $clog2(DEPTH)+1 bits. Address = low bits. empty = (wptr==rptr). full = (low bits equal, MSB differs). level is kept as a register, updated with push/pop, and must always equal wptr-rptr.
- push = avalid & aready. pop = bvalid & bready.
- aready = ~flush & (~full | OVERWRITE). aready must not depend on bready, so there is no same-cycle pass-through when full in blocking mode.
- bvalid = ~empty & ~flush. bdata = mem[rptr addr], read combinationally from registered storage.
- Latency: a word pushed at edge N gives bvalid=1 at the cycle after edge N, provided the FIFO was empty. Minimum write-to-read latency is 1 cycle.
- push only: write mem[wptr], wptr++, level++.
- pop only: rptr++, level--.
- push & pop, not full: both pointers advance; level unchanged.
- Full, blocking mode: push cannot occur (aready=0). A pop that cycle frees one slot, and aready rises the next cycle.
- Full, OVERWRITE=1, push & ~pop: write at wptr (this slot equals the oldest slot), wptr++, rptr++, level stays DEPTH, drop_count++ (saturating). The oldest word is lost; the next bdata is the second-oldest word.
- Full, OVERWRITE=1, push & pop: normal simultaneous push/pop. No drop; drop_count unchanged.
- Empty: pop cannot occur (bvalid=0). bready while empty has no effect.
- flush=1: next edge wptr=rptr=0, level=0. Any push or pop that cycle is suppressed (aready=bvalid=0). drop_count is held.
- reset has priority over flush; flush has priority over push/pop.
- Pointer wrap: wraps naturally mod 2*DEPTH. Data order must be preserved across any number of wraps.
- almost_full and almost_empty are combinational from the registered level, so they are valid the same cycle as level.
- drop_count stays at 2^CNT_WIDTH-1 once reached. Only reset clears it.

Test Plan:
- Reset, then DEPTH=4 blocking: push 0xA0..0xA3 with bready=0 -> level 1,2,3,4; aready=0 after the 4th push; almost_full=1 from level 3. Then bready=1 -> bdata A0,A1,A2,A3 in order; bvalid=0 after; almost_empty=1 at level<=1.
- Continuous push and pop with avalid=bready=1 for 20 words, incrementing data -> 1-cycle latency, level held at 1, output sequence identical across pointer wrap.
- Full in blocking mode, push and pop in the same cycle -> only the pop occurs; level goes 4->3; aready=1 the next cycle.
- OVERWRITE=1, DEPTH=4: push 1..6 with bready=0 -> level=4, drop_count=2, drain yields 3,4,5,6. Repeat with bready=1 on the 5th push -> no drop for that cycle.
- flush asserted while level=3 with avalid=1 -> aready=bvalid=0 that cycle, level=0 next cycle, pushed word not stored, drop_count unchanged. A reset asserted the same cycle also clears drop_count.
- CNT_WIDTH=2, OVERWRITE=1, full FIFO, push 5 extra words -> drop_count sequence 1,2,3,3,3.
